// File: rtl/bitcoin_pkg.sv
// bitcoin_pkg: shared scanner state type, report-word layout and hasher defaults
package bitcoin_pkg;
  localparam int DEF_NUM_NONCES = 16;
  localparam int FOUND_BIT = 31;
  localparam int NONCE_LSB = 16;
  localparam int COUNT_LSB = 0;
  typedef enum logic [2:0] {IDLE, PRIME, SCAN, REPORT, WRITE, WRITE2} scan_state_e;
  function automatic logic [31:0] report_word(input logic f, input logic [7:0] n, input logic [7:0] c);
    report_word = '0;
    report_word[FOUND_BIT] = f;
    report_word[NONCE_LSB+:8] = n;
    report_word[COUNT_LSB+:8] = c;
  endfunction
endpackage

// File: rtl/nonce_result_scanner_if.sv
// nonce_result_scanner_if: shared-memory port between the scanner and the memory
interface nonce_result_scanner_if;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  modport master(output mem_clk, mem_we, mem_addr, mem_write_data, input mem_read_data);
  modport slave(input mem_clk, mem_we, mem_addr, mem_write_data, output mem_read_data);
endinterface

// File: rtl/nonce_result_scanner_compare.sv
// hash_compare_acc: strict unsigned hash<target compare with hit count, first hit and optional minimum (MIN_HASH_TRACK_EN)
module hash_compare_acc #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_cap,
  input  logic [CNT_W-1:0] i_idx,
  input  logic [31:0]      i_data,
  input  logic [31:0]      i_target,
  output logic [CNT_W-1:0] o_first,
  output logic [CNT_W-1:0] o_count,
`ifdef MIN_HASH_TRACK_EN
  output logic [31:0]      o_min_hash,
  output logic [CNT_W-1:0] o_min_nonce,
`endif
  output logic             o_found
);
  logic             r_found;
  logic [CNT_W-1:0] r_first;
  logic [CNT_W-1:0] r_count;
  logic             w_hit;
  assign w_hit   = i_data < i_target;
  assign o_found = r_found;
  assign o_first = r_first;
  assign o_count = r_count;
  // count hits and remember the earliest hit index
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_found <= 1'b0;
      r_first <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_found <= 1'b0;
      r_first <= '0;
      r_count <= '0;
    end else if (i_cap && w_hit) begin
      r_count <= r_count + CNT_W'(1);
      if (!r_found) begin
        r_first <= i_idx;
        r_found <= 1'b1;
      end
    end
`ifdef MIN_HASH_TRACK_EN
  logic [31:0]      r_min_hash;
  logic [CNT_W-1:0] r_min_nonce;
  assign o_min_hash  = r_min_hash;
  assign o_min_nonce = r_min_nonce;
  // strict less-than so ties keep the earlier nonce
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_min_hash  <= '1;
      r_min_nonce <= '0;
    end else if (i_clear) begin
      r_min_hash  <= '1;
      r_min_nonce <= '0;
    end else if (i_cap && i_data < r_min_hash) begin
      r_min_hash  <= i_data;
      r_min_nonce <= i_idx;
    end
`endif
endmodule

// File: rtl/nonce_result_scanner.sv
// nonce_result_scanner: scans NUM_NONCES hash words against a target and writes a report word (MIN_HASH_TRACK_EN adds min tracking)
module nonce_result_scanner import bitcoin_pkg::*; #(
  parameter int NUM_NONCES = DEF_NUM_NONCES,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [15:0]      result_addr,
  input  logic [15:0]      report_addr,
  input  logic [31:0]      target,
  output logic             done,
  output logic             found,
  output logic [CNT_W-1:0] first_nonce,
  output logic [CNT_W-1:0] valid_count,
`ifdef MIN_HASH_TRACK_EN
  output logic [31:0]      min_hash,
  output logic [CNT_W-1:0] min_nonce,
`endif
  nonce_result_scanner_if.master mem
);
  scan_state_e      r_state;
  logic [15:0]      r_report_addr;
  logic [31:0]      r_target;
  logic [CNT_W-1:0] r_idx;
  logic             r_done;
  logic             r_we;
  logic [15:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             w_clear;
  logic             w_cap;
  assign w_clear            = r_state == IDLE && start;
  assign w_cap              = r_state == SCAN;
  assign done               = r_done;
  assign mem.mem_clk        = clk;
  assign mem.mem_we         = r_we;
  assign mem.mem_addr       = r_addr;
  assign mem.mem_write_data = r_wdata;
  hash_compare_acc #(.CNT_W(CNT_W)) u_acc (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clear    (w_clear),
    .i_cap      (w_cap),
    .i_idx      (r_idx),
    .i_data     (mem.mem_read_data),
    .i_target   (r_target),
    .o_first    (first_nonce),
    .o_count    (valid_count),
`ifdef MIN_HASH_TRACK_EN
    .o_min_hash (min_hash),
    .o_min_nonce(min_nonce),
`endif
    .o_found    (found)
  );
  // read pipeline: address leads captured data by two edges, so PRIME issues the second address
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state       <= IDLE;
      r_report_addr <= '0;
      r_target      <= '0;
      r_idx         <= '0;
      r_done        <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
    end else
      case (r_state)
        IDLE: if (start) begin
          r_report_addr <= report_addr;
          r_target      <= target;
          r_idx         <= '0;
          r_done        <= 1'b0;
          r_we          <= 1'b0;
          r_addr        <= result_addr;
          r_state       <= PRIME;
        end
        PRIME: begin
          r_addr  <= r_addr + 16'd1;
          r_state <= SCAN;
        end
        SCAN: begin
          r_addr  <= r_addr + 16'd1;
          r_idx   <= r_idx + CNT_W'(1);
          r_state <= r_idx == CNT_W'(NUM_NONCES - 1) ? REPORT : SCAN;
        end
        REPORT: begin
          r_we    <= 1'b1;
          r_addr  <= r_report_addr;
          r_wdata <= report_word(found, 8'(first_nonce), 8'(valid_count));
          r_state <= WRITE;
        end
`ifdef MIN_HASH_TRACK_EN
        WRITE: begin
          r_addr  <= r_report_addr + 16'd1;
          r_wdata <= min_hash;
          r_state <= WRITE2;
        end
        WRITE2: begin
          r_we    <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
`else
        WRITE: begin
          r_we    <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
`endif
        default: r_state <= IDLE;
      endcase
endmodule

// File: tb/tb_nonce_result_scanner.sv
// tb_nonce_result_scanner: directed table-driven check of scan results, report writes and timing
module tb_nonce_result_scanner;
  localparam int N = 16;
`ifdef MIN_HASH_TRACK_EN
  localparam int XTRA = 1;
`else
  localparam int XTRA = 0;
`endif
  logic        clk = 0, reset_n = 0, start = 0;
  logic [15:0] result_addr = 0, report_addr = 0;
  logic [31:0] target = 0;
  logic        done, found;
  logic [7:0]  first_nonce, valid_count;
`ifdef MIN_HASH_TRACK_EN
  logic [31:0] min_hash;
  logic [7:0]  min_nonce;
`endif
  nonce_result_scanner_if mem();
  nonce_result_scanner #(.NUM_NONCES(N), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .result_addr(result_addr), .report_addr(report_addr), .target(target),
    .done(done), .found(found), .first_nonce(first_nonce), .valid_count(valid_count),
`ifdef MIN_HASH_TRACK_EN
    .min_hash(min_hash), .min_nonce(min_nonce),
`endif
    .mem(mem)
  );
  always #5 clk = ~clk;
  logic [31:0] ram [65536];
  int          cyc = 0, wr_n = 0;
  logic [15:0] wa [4];
  logic [31:0] wd [4];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem.mem_read_data <= ram[mem.mem_addr];
    if (mem.mem_we) begin
      wa[wr_n % 4] <= mem.mem_addr;
      wd[wr_n % 4] <= mem.mem_write_data;
      wr_n <= wr_n + 1;
    end
  end
  int   total = 0, bad = 0;
  logic da;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic fill(input int p);
    for (int i = 0; i < 18; i++) begin
      logic [31:0] v;
      case (p)
        0: v = 32'h100 + i;
        1: v = 32'hFFFFFFFF;
        2: v = i == 11 ? 32'h5 : i == 3 ? 32'h6 : 32'h80000000;
        3: v = i % 2 == 1 ? 32'h12345678 : 32'hFFFFFFFF;
        default: v = (i == 4 || i == 9) ? 32'h2 : 32'h80000000;
      endcase
      ram[16'h40 + i] = i < N ? v : 32'h0;
    end
  endtask
  task automatic run(input logic [15:0] rp, input logic [31:0] tg, output int lat);
    int c0;
    @(negedge clk);
    result_addr = 16'h40; report_addr = rp; target = tg; start = 1;
    @(posedge clk); #1;
    start = 0; c0 = cyc; da = done; lat = -1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = cyc - c0; break; end
    end
  endtask
  typedef struct {
    int pat; logic [31:0] tgt; logic f; logic [7:0] fn; logic [7:0] vc;
    logic [31:0] rep; logic [31:0] mh; logic [7:0] mn;
  } vec_t;
  vec_t v [6];
  task automatic do_vec(input int k);
    int lat, w0;
    logic [15:0] rp;
    rp = 16'h200 + 16'(k * 4);
    fill(v[k].pat);
    w0 = wr_n;
    run(rp, v[k].tgt, lat);
    chk($sformatf("v%0d latency", k), lat, N + 3 + XTRA);
    chk($sformatf("v%0d found", k), found, v[k].f);
    chk($sformatf("v%0d first_nonce", k), first_nonce, v[k].fn);
    chk($sformatf("v%0d valid_count", k), valid_count, v[k].vc);
    chk($sformatf("v%0d writes", k), wr_n - w0, 1 + XTRA);
    chk($sformatf("v%0d report addr", k), wa[w0 % 4], rp);
    chk($sformatf("v%0d report word", k), wd[w0 % 4], v[k].rep);
`ifdef MIN_HASH_TRACK_EN
    chk($sformatf("v%0d min_hash", k), min_hash, v[k].mh);
    chk($sformatf("v%0d min_nonce", k), min_nonce, v[k].mn);
    chk($sformatf("v%0d min addr", k), wa[(w0 + 1) % 4], rp + 16'd1);
    chk($sformatf("v%0d min word", k), wd[(w0 + 1) % 4], v[k].mh);
`endif
  endtask
  initial begin
    int lat, w0, c0;
    v[0] = '{0, 32'h00000108, 1, 0,  8, 32'h80000008, 32'h00000100, 0};
    v[1] = '{1, 32'h10000000, 0, 0,  0, 32'h00000000, 32'hFFFFFFFF, 0};
    v[2] = '{2, 32'h00000006, 1, 11, 1, 32'h800B0001, 32'h00000005, 11};
    v[3] = '{0, 32'h00000000, 0, 0,  0, 32'h00000000, 32'h00000100, 0};
    v[4] = '{3, 32'hFFFFFFFF, 1, 1,  8, 32'h80010008, 32'h12345678, 1};
    v[5] = '{4, 32'h00000003, 1, 4,  2, 32'h80040002, 32'h00000002, 4};
    repeat (3) @(posedge clk);
    #1;
    chk("rst done", done, 0);
    chk("rst found", found, 0);
    chk("rst first", first_nonce, 0);
    chk("rst count", valid_count, 0);
    chk("rst we", mem.mem_we, 0);
    chk("rst addr", mem.mem_addr, 0);
    chk("rst wdata", mem.mem_write_data, 0);
`ifdef MIN_HASH_TRACK_EN
    chk("rst min_hash", min_hash, 32'hFFFFFFFF);
    chk("rst min_nonce", min_nonce, 0);
`endif
    @(negedge clk);
    reset_n = 1;
    for (int k = 0; k < 6; k++) do_vec(k);
    fill(0);
    @(negedge clk);
    result_addr = 16'h40; report_addr = 16'h300; target = 32'h108; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid found before rst", found, 1);
    w0 = wr_n;
    reset_n = 0;
    #1;
    chk("mid rst found", found, 0);
    chk("mid rst first", first_nonce, 0);
    chk("mid rst count", valid_count, 0);
    chk("mid rst done", done, 0);
    chk("mid rst addr", mem.mem_addr, 0);
    repeat (25) @(posedge clk);
    #1;
    chk("mid rst no write", wr_n - w0, 0);
    chk("mid rst still idle", done, 0);
    @(negedge clk);
    reset_n = 1;
    do_vec(0);
    fill(2);
    w0 = wr_n;
    @(negedge clk);
    result_addr = 16'h40; report_addr = 16'h320; target = 32'h6; start = 1;
    @(posedge clk); #1;
    start = 0; c0 = cyc;
    chk("busy done cleared", done, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    lat = -1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = cyc - c0; break; end
    end
    chk("busy latency", lat, N + 3 + XTRA);
    chk("busy writes", wr_n - w0, 1 + XTRA);
    chk("busy first", first_nonce, 11);
    chk("busy report", wd[w0 % 4], 32'h800B0001);
    repeat (5) @(posedge clk);
    #1;
    chk("done held", done, 1);
    chk("found held", found, 1);
    chk("count held", valid_count, 1);
    fill(1);
    run(16'h340, 32'h10000000, lat);
    chk("accept clears done", da, 0);
    chk("after busy latency", lat, N + 3 + XTRA);
    chk("after busy found", found, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
